// File: rtl/booth_r4_mult_seq_if.sv
// Handshake bundle for booth_r4_mult_seq; the accumulator pins exist only when
// BOOTH_ACC_EN is defined.
interface booth_r4_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     q_in;
    logic [WIDTH-1:0]     m_in;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   out;
`ifdef BOOTH_ACC_EN
    logic                 acc_clr;
    logic [2*WIDTH+7:0]   acc;
`endif

    modport master (
        output start, signed_mode, q_in, m_in,
        input  busy, done, out
`ifdef BOOTH_ACC_EN
        , output acc_clr
        , input  acc
`endif
    );

    modport slave (
        input  start, signed_mode, q_in, m_in,
        output busy, done, out
`ifdef BOOTH_ACC_EN
        , input  acc_clr
        , output acc
`endif
    );
endinterface

// File: rtl/booth_r4_mult_seq.sv
// Sequential radix-4 Booth multiplier, one recoded digit per clock, signed/unsigned.
// Optional product accumulator enabled by defining BOOTH_ACC_EN.
module booth_r4_mult_seq #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    booth_r4_mult_seq_if.slave bus
);
    localparam int W2   = WIDTH + 2;
    localparam int ITER = W2 / 2;
    localparam int PW   = 2 * W2 + 1;
    localparam int CW   = $clog2(ITER + 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_r4_mult_seq: WIDTH must be even and >= 4");
        end
    endgenerate

    // state | meaning
    // IDLE  | waiting for start, operands latched on acceptance
    // RUN   | one Booth digit added and P shifted per cycle, ITER cycles
    // DONE  | product copied to out, done pulses in the following cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;
    logic   load, step, finish;

    logic [PW-1:0]          p;
    logic signed [W2-1:0]   m_reg;
    logic [CW-1:0]          count;
    logic [W2-1:0]          q_ext;
    logic signed [W2+1:0]   m_x;
    logic signed [W2+1:0]   addend;
    logic signed [W2+1:0]   sum;
    logic                   done_reg;
    logic [2*WIDTH-1:0]     out_reg;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == CW'(ITER - 1)) state_next = DONE;
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_reg;
    assign bus.out  = out_reg;

    assign q_ext = bus.signed_mode ? {{2{bus.q_in[WIDTH-1]}}, bus.q_in}
                                   : {2'b00, bus.q_in};
    assign m_x   = {{2{m_reg[W2-1]}}, m_reg};

    always_comb begin
        addend = '0;
        case (p[2:0])
            3'b001, 3'b010: addend = m_x;
            3'b011:         addend = m_x <<< 1;
            3'b100:         addend = -(m_x <<< 1);
            3'b101, 3'b110: addend = -m_x;
            default:        addend = '0;
        endcase
    end

    // Two guard bits keep A + 2M from overflowing before the arithmetic shift.
    assign sum = $signed({{2{p[PW-1]}}, p[PW-1:W2+1]}) + addend;

    always_ff @(posedge clk) begin
        if (rst) begin
            p        <= '0;
            m_reg    <= '0;
            count    <= '0;
            done_reg <= 1'b0;
            out_reg  <= '0;
        end else begin
            done_reg <= finish;
            if (load) begin
                p     <= {{W2{1'b0}}, q_ext, 1'b0};
                m_reg <= bus.signed_mode ? $signed({{2{bus.m_in[WIDTH-1]}}, bus.m_in})
                                         : $signed({2'b00, bus.m_in});
                count <= '0;
            end else if (step) begin
                p     <= {sum, p[W2:2]};
                count <= count + CW'(1);
            end
            if (finish) out_reg <= p[2*WIDTH:1];
        end
    end

`ifdef BOOTH_ACC_EN
    logic                 mode_reg;
    logic [2*WIDTH+7:0]   acc_reg;
    logic [2*WIDTH+7:0]   prod_ext;

    assign prod_ext = mode_reg ? {{8{p[2*WIDTH]}}, p[2*WIDTH:1]}
                               : {8'd0, p[2*WIDTH:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg <= 1'b0;
            acc_reg  <= '0;
        end else begin
            if (load) mode_reg <= bus.signed_mode;
            acc_reg <= (bus.acc_clr ? '0 : acc_reg) + (finish ? prod_ext : '0);
        end
    end

    assign bus.acc = acc_reg;
`endif
endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// Self-checking bench for booth_r4_mult_seq: directed corners at WIDTH=8, random at WIDTH=16.
module tb_booth_r4_mult_seq;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    booth_r4_mult_seq_if #(.WIDTH(8))  bus8 ();
    booth_r4_mult_seq_if #(.WIDTH(16)) bus16 ();

    booth_r4_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    booth_r4_mult_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    function automatic logic [15:0] ref8(input logic [7:0] q, input logic [7:0] m, input logic sm);
        int a, b;
        a = sm ? int'($signed(q)) : int'(q);
        b = sm ? int'($signed(m)) : int'(m);
        return 16'(a * b);
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] q, input logic [15:0] m, input logic sm);
        longint a, b;
        a = sm ? longint'($signed(q)) : longint'(q);
        b = sm ? longint'($signed(m)) : longint'(m);
        return 32'(a * b);
    endfunction

    // Launch one op; lat = edges from acceptance to the done cycle, -1 on timeout.
    task automatic drive8(input logic [7:0] q, input logic [7:0] m, input logic sm,
                          output logic [15:0] res, output int lat);
        @(posedge clk); #1;
        bus8.start = 1'b1; bus8.q_in = q; bus8.m_in = m; bus8.signed_mode = sm;
        @(posedge clk); #1;
        bus8.start = 1'b0; bus8.q_in = $urandom; bus8.m_in = $urandom; bus8.signed_mode = $urandom;
        lat = -1; res = 'x;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus8.done) begin lat = i; res = bus8.out; break; end
        end
    endtask

    task automatic drive16(input logic [15:0] q, input logic [15:0] m, input logic sm,
                           output logic [31:0] res, output int lat);
        @(posedge clk); #1;
        bus16.start = 1'b1; bus16.q_in = q; bus16.m_in = m; bus16.signed_mode = sm;
        @(posedge clk); #1;
        bus16.start = 1'b0; bus16.q_in = $urandom; bus16.m_in = $urandom;
        lat = -1; res = 'x;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (bus16.done) begin lat = i; res = bus16.out; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: busy=%b done=%b, want 0 0", bus8.busy, bus8.done);
        end
        checks++;
        if (bus8.out !== 16'h0000) begin
            errors++; $display("FAIL reset_out8: got %h want 0000", bus8.out);
        end
        checks++;
        if (bus16.out !== 32'h0 || bus16.busy !== 1'b0) begin
            errors++; $display("FAIL reset_16: out=%h busy=%b want 0 0", bus16.out, bus16.busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_latency;
        logic [15:0] res;
        int lat;
        drive8(8'd123, 8'd90, 1'b0, res, lat);
        checks++;
        if (lat != 6) begin errors++; $display("FAIL t1_latency: got %0d want 6", lat); end
        checks++;
        if (res !== 16'h2B3E) begin errors++; $display("FAIL t1_product: got %h want 2b3e", res); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus8.out !== 16'h2B3E || bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            errors++;
            $display("FAIL t1_hold: out=%h busy=%b done=%b want 2b3e 0 0", bus8.out, bus8.busy, bus8.done);
        end
    endtask

    task automatic test_corners;
        logic [7:0]  qs [8] = '{8'hFB, 8'hFB, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h80, 8'h7F};
        logic [7:0]  ms [8] = '{8'h07, 8'h07, 8'h80, 8'hFF, 8'hA5, 8'hFF, 8'h7F, 8'h80};
        logic        ss [8] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        logic [15:0] es [8] = '{16'hFFDD, 16'h06DD, 16'h4000, 16'hFE01,
                                16'h0000, 16'h0000, 16'hC080, 16'h3F80};
        logic [15:0] res;
        int lat;
        for (int i = 0; i < 8; i++) begin
            drive8(qs[i], ms[i], ss[i], res, lat);
            checks++;
            if (res !== es[i] || lat != 6) begin
                errors++;
                $display("FAIL corner_%0d: q=%h m=%h s=%b got %h lat %0d want %h lat 6",
                         i, qs[i], ms[i], ss[i], res, lat, es[i]);
            end
        end
    endtask

    task automatic test_random8;
        logic [7:0]  q, m;
        logic        sm;
        logic [15:0] res;
        int lat;
        for (int i = 0; i < 60; i++) begin
            q = 8'($urandom); m = 8'($urandom); sm = 1'($urandom);
            drive8(q, m, sm, res, lat);
            checks++;
            if (res !== ref8(q, m, sm) || lat != 6) begin
                errors++;
                $display("FAIL rand8: q=%h m=%h s=%b got %h lat %0d want %h", q, m, sm, res, lat, ref8(q, m, sm));
            end
        end
    endtask

    task automatic test_ignore_start;
        int ndone = 0;
        bit seen = 0, dropped = 0;
        logic [15:0] res = 'x;
        @(posedge clk); #1;
        bus8.start = 1'b1; bus8.q_in = 8'h0C; bus8.m_in = 8'h0D; bus8.signed_mode = 1'b0;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (bus8.done) begin ndone++; seen = 1; res = bus8.out; end
            else if (!seen && !bus8.busy) dropped = 1;
            if (i == 1) begin
                bus8.start = 1'b1; bus8.q_in = 8'hFF; bus8.m_in = 8'hFF; bus8.signed_mode = 1'b1;
            end
            if (i == 2) bus8.start = 1'b0;
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL t4_done_count: got %0d want 1", ndone); end
        checks++;
        if (res !== 16'h009C) begin errors++; $display("FAIL t4_product: got %h want 009c", res); end
        checks++;
        if (dropped || bus8.busy !== 1'b0) begin
            errors++; $display("FAIL t4_busy: dropped_early=%0d busy_at_end=%b want 0 0", dropped, bus8.busy);
        end
    endtask

    task automatic test_reset_mid;
        int ndone = 0;
        logic [15:0] res;
        int lat;
        @(posedge clk); #1;
        bus8.start = 1'b1; bus8.q_in = 8'h33; bus8.m_in = 8'h44; bus8.signed_mode = 1'b0;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus8.start = 1'b0;
        checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.out !== 16'h0000) begin
            errors++;
            $display("FAIL t5_abort: busy=%b done=%b out=%h want 0 0 0000", bus8.busy, bus8.done, bus8.out);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus8.done || bus8.busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL t5_quiet: activity cycles %0d want 0", ndone); end
        drive8(8'h12, 8'h34, 1'b0, res, lat);
        checks++;
        if (res !== 16'h03A8 || lat != 6) begin
            errors++; $display("FAIL t5_after: got %h lat %0d want 03a8 lat 6", res, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] res;
        int lat = -1;
        drive8(8'h9C, 8'h21, 1'b1, res, lat);
        checks++;
        if (res !== ref8(8'h9C, 8'h21, 1'b1)) begin
            errors++; $display("FAIL b2b_first: got %h want %h", res, ref8(8'h9C, 8'h21, 1'b1));
        end
        bus8.start = 1'b1; bus8.q_in = 8'hE7; bus8.m_in = 8'h3B; bus8.signed_mode = 1'b0;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus8.done) begin lat = i; res = bus8.out; break; end
        end
        checks++;
        if (lat != 6 || res !== ref8(8'hE7, 8'h3B, 1'b0)) begin
            errors++;
            $display("FAIL b2b_second: got %h lat %0d want %h lat 6", res, lat, ref8(8'hE7, 8'h3B, 1'b0));
        end
    endtask

    task automatic test_random16;
        logic [15:0] q, m;
        logic        sm;
        logic [31:0] res;
        int lat;
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            q = 16'($urandom); m = 16'($urandom);
            sm = (i < 900) ? 1'b1 : 1'b0;
            if (i == 0) begin q = 16'h8000; m = 16'h8000; end
            if (i == 900) begin q = 16'hFFFF; m = 16'hFFFF; end
            drive16(q, m, sm, res, lat);
            checks++;
            if (res !== ref16(q, m, sm) || lat != 10) begin
                errors++;
                if (bad < 10)
                    $display("FAIL rand16: q=%h m=%h s=%b got %h lat %0d want %h lat 10",
                             q, m, sm, res, lat, ref16(q, m, sm));
                bad++;
            end
        end
    endtask

`ifdef BOOTH_ACC_EN
    task automatic test_acc;
        logic [15:0] res;
        int lat;
        bus8.acc_clr = 1'b1;
        @(posedge clk); #1;
        bus8.acc_clr = 1'b0;
        checks++;
        if (bus8.acc !== 24'd0) begin errors++; $display("FAIL acc_clear: got %h want 0", bus8.acc); end
        for (int i = 0; i < 3; i++) drive8(8'd10, 8'd10, 1'b0, res, lat);
        checks++;
        if (bus8.acc !== 24'd300) begin errors++; $display("FAIL acc_sum: got %0d want 300", bus8.acc); end
        bus8.acc_clr = 1'b1;
        drive8(8'hFB, 8'h07, 1'b1, res, lat);
        checks++;
        if (bus8.acc !== 24'hFFFFDD) begin
            errors++; $display("FAIL acc_clr_done: got %h want ffffdd", bus8.acc);
        end
        bus8.acc_clr = 1'b0;
        drive8(8'h02, 8'h03, 1'b1, res, lat);
        checks++;
        if (bus8.acc !== 24'hFFFFE3) begin
            errors++; $display("FAIL acc_signed: got %h want ffffe3", bus8.acc);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus8.start = 1'b0;  bus8.signed_mode = 1'b0;  bus8.q_in = '0;  bus8.m_in = '0;
        bus16.start = 1'b0; bus16.signed_mode = 1'b0; bus16.q_in = '0; bus16.m_in = '0;
`ifdef BOOTH_ACC_EN
        bus8.acc_clr = 1'b0;
        bus16.acc_clr = 1'b0;
`endif
        test_reset();
        test_latency();
        test_corners();
        test_random8();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random16();
`ifdef BOOTH_ACC_EN
        test_acc();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
